// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the instruction/data RAM arbiter
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: enable-gated up counter that sticks at its all-ones value
module arb_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    output logic [W-1:0] count
);

    // count enabled cycles, holding once every bit is set
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter, data path has priority over fetch.
// Optional statistics counters are built only when ARB_STATS_EN is defined.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iREN,
    input  word_t            iaddr,
    input  logic             dREN,
    input  logic             dWEN,
    input  word_t            daddr,
    input  word_t            dstore,
    input  logic [1:0]       ramstate,
    input  word_t            ramload,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    output logic             iwait,
    output logic             dwait,
    output word_t            iload,
    output word_t            dload,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] dcount,
    output logic [CNT_W-1:0] stall_count
);

    arb_state_t state;
    logic       d_req, access, d_done, i_done;

    assign d_req  = dREN | dWEN;
    assign access = ramstate_t'(ramstate) == ACCESS;
    // a dropped request in its own ACCESS cycle is an abort, not a completion
    assign d_done = state == DREQ && d_req && access;
    assign i_done = state == IREQ && iREN && access;

    // ownership FSM: one RAM transaction at a time, released on ACCESS or abort
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else begin
            case (state)
                IDLE:    state <= d_req ? DREQ : iREN ? IREQ : IDLE;
                DREQ:    state <= (!d_req || access) ? IDLE : DREQ;
                IREQ:    state <= (!iREN || access) ? IDLE : IREQ;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port follows the owning requester; completion is same-cycle as ACCESS
    always_comb begin
        ramREN   = state == IREQ ? 1'b1 : state == DREQ ? dREN & ~dWEN : 1'b0;
        ramWEN   = state == DREQ && dWEN;
        ramaddr  = state == DREQ ? daddr : state == IREQ ? iaddr : '0;
        ramstore = state == DREQ ? dstore : '0;
        dwait    = !d_done;
        iwait    = !i_done;
        dload    = d_done ? ramload : '0;
        iload    = i_done ? ramload : '0;
    end

`ifdef ARB_STATS_EN
    arb_sat_counter #(.W(CNT_W)) u_icount (
        .CLK(CLK), .nRST(nRST), .en(i_done), .count(icount)
    );
    arb_sat_counter #(.W(CNT_W)) u_dcount (
        .CLK(CLK), .nRST(nRST), .en(d_done), .count(dcount)
    );
    arb_sat_counter #(.W(CNT_W)) u_stall (
        .CLK(CLK), .nRST(nRST), .en(state != IDLE && !access), .count(stall_count)
    );
`else
    assign icount      = '0;
    assign dcount      = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter (stats expectations follow ARB_STATS_EN)
module tb_memory_arbiter;

    localparam int CW = 3;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

    logic          CLK, nRST, iREN, dREN, dWEN;
    logic [31:0]   iaddr, daddr, dstore, ramload;
    logic [1:0]    ramstate;
    logic          ramREN, ramWEN, iwait, dwait;
    logic [31:0]   ramaddr, ramstore, iload, dload;
    logic [CW-1:0] icount, dcount, stall_count;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    memory_arbiter #(.CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .icount(icount), .dcount(dcount), .stall_count(stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard: every completion pulse must match the oldest expected transaction
    always @(negedge CLK) begin
        #2;
        if (nRST && (!dwait || !iwait)) begin
            total++;
            if (!dwait && !iwait) begin
                $display("FAIL sb_both: iwait=%0b dwait=%0b, required only one low", iwait, dwait);
            end else if (q.size() == 0) begin
                $display("FAIL sb_unexpected: completion dwait=%0b iwait=%0b addr=%h, required none", dwait, iwait, ramaddr);
            end else begin
                exp_t e;
                logic [31:0] got;
                e = q.pop_front();
                got = !dwait ? dload : iload;
                if (e.is_d !== !dwait || e.addr !== ramaddr || e.data !== got)
                    $display("FAIL sb_txn: is_d=%0b addr=%h load=%h, required is_d=%0b addr=%h load=%h",
                             !dwait, ramaddr, got, e.is_d, e.addr, e.data);
                else passed++;
            end
        end
    end

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ramstate = R_FREE; ramload = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        idle_inputs();
        q.delete();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1;
    endtask

    task automatic test_reset();
        nRST = 0;
        idle_inputs();
        iREN = 1; iaddr = 32'h400;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        total++; if (ramREN !== 1'b0) $display("FAIL rst_ramREN: got %0b, required 0", ramREN); else passed++;
        total++; if (iwait !== 1'b1 || dwait !== 1'b1) $display("FAIL rst_wait: got i=%0b d=%0b, required 1/1", iwait, dwait); else passed++;
        total++; if (iload !== 0 || ramaddr !== 0) $display("FAIL rst_zero: got iload=%h ramaddr=%h, required 0/0", iload, ramaddr); else passed++;
        total++; if (icount !== 0 || dcount !== 0 || stall_count !== 0)
            $display("FAIL rst_cnt: got %0d/%0d/%0d, required 0/0/0", icount, dcount, stall_count); else passed++;
        nRST = 1;
        q.push_back('{1'b0, 32'h400, 32'h2400_0001});
        @(negedge CLK);
        ramstate = R_ACC; ramload = 32'h2400_0001;
        #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h400) $display("FAIL rst_first: got ren=%0b addr=%h, required 1/400", ramREN, ramaddr); else passed++;
        total++; if (iwait !== 1'b0 || iload !== 32'h2400_0001) $display("FAIL rst_load: got iwait=%0b iload=%h, required 0/24000001", iwait, iload); else passed++;
        @(negedge CLK);
        iREN = 0; ramstate = R_FREE;
        #1;
        total++; if (ramREN !== 1'b0 || iwait !== 1'b1) $display("FAIL rst_after: got ren=%0b iwait=%0b, required 0/1", ramREN, iwait); else passed++;
        total++; if (q.size() != 0) $display("FAIL rst_q: got %0d pending, required 0", q.size()); else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h100;
        q.push_back('{1'b1, 32'h100, 32'hAAAA_0001});
        q.push_back('{1'b0, 32'h500, 32'hBBBB_0002});
        #1;
        total++; if (ramREN !== 1'b0) $display("FAIL sim_idle: got ren=%0b, required 0", ramREN); else passed++;
        @(negedge CLK);
        ramstate = R_ACC; ramload = 32'hAAAA_0001;
        #1;
        total++; if (ramaddr !== 32'h100 || ramREN !== 1'b1 || ramWEN !== 1'b0)
            $display("FAIL sim_dfirst: got addr=%h ren=%0b wen=%0b, required 100/1/0", ramaddr, ramREN, ramWEN); else passed++;
        total++; if (iwait !== 1'b1) $display("FAIL sim_iheld: got iwait=%0b, required 1", iwait); else passed++;
        @(negedge CLK);
        dREN = 0; ramstate = R_FREE;
        #1;
        total++; if (ramREN !== 1'b0 || ramaddr !== 0 || iwait !== 1'b1)
            $display("FAIL sim_bubble: got ren=%0b addr=%h iwait=%0b, required 0/0/1", ramREN, ramaddr, iwait); else passed++;
        @(negedge CLK);
        ramstate = R_ACC; ramload = 32'hBBBB_0002;
        #1;
        total++; if (ramaddr !== 32'h500 || ramREN !== 1'b1) $display("FAIL sim_ifetch: got addr=%h ren=%0b, required 500/1", ramaddr, ramREN); else passed++;
        @(negedge CLK);
        iREN = 0; ramstate = R_FREE;
        #1;
        total++; if (q.size() != 0) $display("FAIL sim_q: got %0d pending, required 0", q.size()); else passed++;
    endtask

    task automatic test_write();
        do_reset();
        dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramload = 32'h1234_5678;
        q.push_back('{1'b1, 32'h200, 32'h1234_5678});
        #1;
        total++; if (ramWEN !== 1'b0) $display("FAIL wr_idle: got wen=%0b, required 0", ramWEN); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            ramstate = R_BUSY;
            #1;
            total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hDEAD_BEEF || dwait !== 1'b1)
                $display("FAIL wr_busy%0d: got wen=%0b ren=%0b addr=%h st=%h dwait=%0b, required 1/0/200/deadbeef/1",
                         c, ramWEN, ramREN, ramaddr, ramstore, dwait);
            else passed++;
        end
        @(negedge CLK);
        ramstate = R_ACC;
        #1;
        total++; if (ramWEN !== 1'b1 || dwait !== 1'b0) $display("FAIL wr_acc: got wen=%0b dwait=%0b, required 1/0", ramWEN, dwait); else passed++;
        @(negedge CLK);
        dWEN = 0; ramstate = R_FREE;
        #1;
        total++; if (stall_count !== (STATS ? CW'(3) : CW'(0)) || dcount !== (STATS ? CW'(1) : CW'(0)))
            $display("FAIL wr_cnt: got stall=%0d dcount=%0d, required %0d/%0d", stall_count, dcount, STATS ? 3 : 0, STATS ? 1 : 0);
        else passed++;
        total++; if (q.size() != 0) $display("FAIL wr_q: got %0d pending, required 0", q.size()); else passed++;
    endtask

    task automatic test_error_retry();
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'hCAFE_F00D; ramload = 32'h0BAD_0001;
        q.push_back('{1'b1, 32'h300, 32'h0BAD_0001});
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            ramstate = R_ERR;
            #1;
            total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || ramstore !== 32'hCAFE_F00D || dwait !== 1'b1 || dload !== 0)
                $display("FAIL err_hold%0d: got wen=%0b ren=%0b addr=%h st=%h dwait=%0b dload=%h, required 1/0/300/cafef00d/1/0",
                         c, ramWEN, ramREN, ramaddr, ramstore, dwait, dload);
            else passed++;
        end
        @(negedge CLK);
        ramstate = R_ACC;
        @(negedge CLK);
        dREN = 0; dWEN = 0; ramstate = R_FREE;
        @(negedge CLK);
        #1;
        total++; if (stall_count !== (STATS ? CW'(2) : CW'(0)) || dcount !== (STATS ? CW'(1) : CW'(0)))
            $display("FAIL err_cnt: got stall=%0d dcount=%0d, required %0d/%0d", stall_count, dcount, STATS ? 2 : 0, STATS ? 1 : 0);
        else passed++;
        total++; if (q.size() != 0) $display("FAIL err_q: got %0d pending, required 0", q.size()); else passed++;
    endtask

    task automatic test_abort();
        do_reset();
        dREN = 1; daddr = 32'h700;
        @(negedge CLK);
        ramstate = R_BUSY;
        #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h700) $display("FAIL ab_drive: got ren=%0b addr=%h, required 1/700", ramREN, ramaddr); else passed++;
        @(negedge CLK);
        dREN = 0;
        #1;
        total++; if (ramREN !== 1'b0 || dwait !== 1'b1) $display("FAIL ab_drop: got ren=%0b dwait=%0b, required 0/1", ramREN, dwait); else passed++;
        @(negedge CLK);
        ramstate = R_ACC;
        #1;
        total++; if (ramaddr !== 0 || ramREN !== 1'b0 || dwait !== 1'b1)
            $display("FAIL ab_idle: got addr=%h ren=%0b dwait=%0b, required 0/0/1", ramaddr, ramREN, dwait); else passed++;
        total++; if (dcount !== 0 || stall_count !== (STATS ? CW'(2) : CW'(0)))
            $display("FAIL ab_cnt: got dcount=%0d stall=%0d, required 0/%0d", dcount, stall_count, STATS ? 2 : 0);
        else passed++;
        ramstate = R_FREE;
    endtask

    task automatic test_async_reset();
        do_reset();
        iREN = 1; iaddr = 32'h900;
        @(negedge CLK);
        ramstate = R_BUSY;
        #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h900) $display("FAIL ar_drive: got ren=%0b addr=%h, required 1/900", ramREN, ramaddr); else passed++;
        #2;
        nRST = 0;
        #1;
        total++; if (ramREN !== 1'b0 || ramaddr !== 0 || iwait !== 1'b1)
            $display("FAIL ar_drop: got ren=%0b addr=%h iwait=%0b, required 0/0/1", ramREN, ramaddr, iwait); else passed++;
        ramstate = R_ACC;
        #1;
        total++; if (iwait !== 1'b1 || iload !== 0) $display("FAIL ar_nodone: got iwait=%0b iload=%h, required 1/0", iwait, iload); else passed++;
        @(negedge CLK);
        iREN = 0; ramstate = R_FREE; nRST = 1;
        @(negedge CLK);
        #1;
        total++; if (ramREN !== 1'b0 || icount !== 0) $display("FAIL ar_idle: got ren=%0b icount=%0d, required 0/0", ramREN, icount); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            iREN = 1; iaddr = 32'h800 + 32'(k * 4); ramstate = R_FREE;
            q.push_back('{1'b0, 32'h800 + 32'(k * 4), 32'h1000 + 32'(k)});
            @(negedge CLK);
            ramstate = R_ACC; ramload = 32'h1000 + 32'(k);
            @(negedge CLK);
        end
        iREN = 0; ramstate = R_FREE;
        #1;
        total++; if (icount !== (STATS ? CW'(7) : CW'(0)) || stall_count !== 0)
            $display("FAIL sat_cnt: got icount=%0d stall=%0d, required %0d/0", icount, stall_count, STATS ? 7 : 0);
        else passed++;
        total++; if (q.size() != 0) $display("FAIL sat_q: got %0d pending, required 0", q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_write();
        test_error_retry();
        test_abort();
        test_async_reset();
        test_saturation();
        @(negedge CLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
